// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_if
// Purpose  : CPU, DMA, memory and statistics signals of the shared memory port
// Revision : 1.0  initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int CNT_W = 16
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_gnt;
    logic          cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_stall;

    logic          dma_req;
    logic          dma_we;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata;
    logic          dma_lock;
    logic          dma_gnt;
    logic          dma_rvalid;
    logic [DW-1:0] dma_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic [CNT_W-1:0] stat_cpu_grants;
    logic [CNT_W-1:0] stat_dma_grants;
    logic [CNT_W-1:0] stat_conflicts;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata, cpu_stall,
        input  dma_req, dma_we, dma_addr, dma_wdata, dma_lock,
        output dma_gnt, dma_rvalid, dma_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output stat_cpu_grants, stat_dma_grants, stat_conflicts
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata, cpu_stall,
        output dma_req, dma_we, dma_addr, dma_wdata, dma_lock,
        input  dma_gnt, dma_rvalid, dma_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  stat_cpu_grants, stat_dma_grants, stat_conflicts
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one memory port between the CPU and a burst-capable DMA
//            master. Define ARB_STATS_EN to build the grant/conflict counters.
// Revision : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MEM_LAT   = 1,
    parameter int MAX_BURST = 8,
    parameter int CNT_W     = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    mem_port_arbiter_if.slave   bus
);
    localparam int C_BEAT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_DMA_BURST = 2'd1,
        ST_CPU_FORCE = 2'd2
    } state_t;

    state_t                state_q;
    logic                  last_cpu_q;
    logic [C_BEAT_W-1:0]   beat_q;
    logic [MEM_LAT-1:0]    tag_v_q;
    logic [MEM_LAT-1:0]    tag_cpu_q;

    logic w_cpu_gnt;
    logic w_dma_gnt;
    logic w_conflict;
    logic w_burst_full;
    logic w_rd_accept;

    assign w_burst_full = (beat_q >= C_BEAT_W'(MAX_BURST));

    // Grants are held low while reset is asserted even if requests are high.
    always_comb begin
        w_cpu_gnt  = 1'b0;
        w_dma_gnt  = 1'b0;
        w_conflict = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.cpu_req && bus.dma_req) begin
                    w_conflict = 1'b1;
                    w_cpu_gnt  = ~last_cpu_q;
                    w_dma_gnt  = last_cpu_q;
                end else begin
                    w_cpu_gnt = bus.cpu_req;
                    w_dma_gnt = bus.dma_req;
                end
            end
            ST_DMA_BURST: w_dma_gnt = bus.dma_req & bus.dma_lock & ~(w_burst_full & bus.cpu_req);
            ST_CPU_FORCE: w_cpu_gnt = bus.cpu_req;
            default: ;
        endcase
        if (!reset_n) begin
            w_cpu_gnt  = 1'b0;
            w_dma_gnt  = 1'b0;
            w_conflict = 1'b0;
        end
    end

    assign w_rd_accept = (w_cpu_gnt & ~bus.cpu_we) | (w_dma_gnt & ~bus.dma_we);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            last_cpu_q <= 1'b0;
            beat_q     <= '0;
            tag_v_q    <= '0;
            tag_cpu_q  <= '0;
        end else begin
            tag_v_q[0]   <= w_rd_accept;
            tag_cpu_q[0] <= w_cpu_gnt;
            for (int i = 1; i < MEM_LAT; i++) begin
                tag_v_q[i]   <= tag_v_q[i-1];
                tag_cpu_q[i] <= tag_cpu_q[i-1];
            end
            case (state_q)
                ST_IDLE: begin
                    if (w_conflict)
                        last_cpu_q <= w_cpu_gnt;
                    if (w_dma_gnt && bus.dma_lock) begin
                        state_q <= ST_DMA_BURST;
                        beat_q  <= C_BEAT_W'(1);
                    end
                end
                ST_DMA_BURST: begin
                    if (!(bus.dma_req && bus.dma_lock))
                        state_q <= ST_IDLE;
                    else if (w_burst_full && bus.cpu_req)
                        state_q <= ST_CPU_FORCE;
                    else if (!w_burst_full)
                        beat_q <= beat_q + C_BEAT_W'(1);
                end
                ST_CPU_FORCE: begin
                    if (w_cpu_gnt) begin
                        state_q    <= ST_IDLE;
                        last_cpu_q <= 1'b1;
                        beat_q     <= '0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.cpu_gnt   = w_cpu_gnt;
    assign bus.dma_gnt   = w_dma_gnt;
    assign bus.mem_en    = w_cpu_gnt | w_dma_gnt;
    assign bus.mem_we    = (w_cpu_gnt & bus.cpu_we) | (w_dma_gnt & bus.dma_we);
    assign bus.mem_addr  = w_cpu_gnt ? bus.cpu_addr  : (w_dma_gnt ? bus.dma_addr  : {AW{1'b0}});
    assign bus.mem_wdata = w_cpu_gnt ? bus.cpu_wdata : (w_dma_gnt ? bus.dma_wdata : {DW{1'b0}});

    assign bus.cpu_rvalid = tag_v_q[MEM_LAT-1] &  tag_cpu_q[MEM_LAT-1];
    assign bus.dma_rvalid = tag_v_q[MEM_LAT-1] & ~tag_cpu_q[MEM_LAT-1];
    assign bus.cpu_rdata  = reset_n ? bus.mem_rdata : {DW{1'b0}};
    assign bus.dma_rdata  = reset_n ? bus.mem_rdata : {DW{1'b0}};

    // The CPU stays stalled until its read data has actually come back.
    assign bus.cpu_stall = reset_n & ((bus.cpu_req & ~w_cpu_gnt) | (|(tag_v_q & tag_cpu_q)));

`ifdef ARB_STATS_EN
    logic [CNT_W-1:0] stat_cpu_q;
    logic [CNT_W-1:0] stat_dma_q;
    logic [CNT_W-1:0] stat_cf_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_cpu_q <= '0;
            stat_dma_q <= '0;
            stat_cf_q  <= '0;
        end else begin
            if (w_cpu_gnt && !(&stat_cpu_q)) stat_cpu_q <= stat_cpu_q + CNT_W'(1);
            if (w_dma_gnt && !(&stat_dma_q)) stat_dma_q <= stat_dma_q + CNT_W'(1);
            if (w_conflict && !(&stat_cf_q)) stat_cf_q  <= stat_cf_q  + CNT_W'(1);
        end
    end

    assign bus.stat_cpu_grants = stat_cpu_q;
    assign bus.stat_dma_grants = stat_dma_q;
    assign bus.stat_conflicts  = stat_cf_q;
`else
    assign bus.stat_cpu_grants = {CNT_W{1'b0}};
    assign bus.stat_dma_grants = {CNT_W{1'b0}};
    assign bus.stat_conflicts  = {CNT_W{1'b0}};
`endif
endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Directed stimulus against a cycle-level arbitration model.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;
    localparam int AW = 32, DW = 32, MEM_LAT = 2, MAX_BURST = 8, CNT_W = 4;
    localparam int SAT = (1 << CNT_W) - 1;
`ifdef ARB_STATS_EN
    localparam int C_STATS = 1;
`else
    localparam int C_STATS = 0;
`endif

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(AW), .DW(DW), .CNT_W(CNT_W)) bus ();

    mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(MEM_LAT), .MAX_BURST(MAX_BURST), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Memory: MEM_LAT-cycle read latency, preloaded while reset is low.
    logic [DW-1:0] mem [0:255];
    logic [DW-1:0] rd_pipe [0:MEM_LAT-1];
    logic          s_en, s_we;
    logic [7:0]    s_idx;
    logic [DW-1:0] s_wdata;
    int            tb_cyc = 0;
    assign bus.mem_rdata = rd_pipe[MEM_LAT-1];

    always @(negedge clk) begin
        s_en    <= bus.mem_en;
        s_we    <= bus.mem_we;
        s_idx   <= bus.mem_addr[9:2];
        s_wdata <= bus.mem_wdata;
    end

    always @(posedge clk) begin
        tb_cyc <= tb_cyc + 1;
        if (!reset_n) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hC0DE_0000 | i;
            for (int i = 0; i < MEM_LAT; i++) rd_pipe[i] <= '0;
        end else begin
            if (s_en && s_we) mem[s_idx] <= s_wdata;
            rd_pipe[0] <= (s_en && !s_we) ? mem[s_idx] : (32'h0BAD_0000 ^ tb_cyc);
            for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
        end
    end

    // Behavioural model: ownership flags, a beat counter and a return queue.
    typedef struct { int due; bit cpu; logic [DW-1:0] data; } ret_t;
    ret_t q[$];
    ret_t nq[$];
    ret_t ent;
    int   cyc = 0;
    bit   m_cpu_owed, m_dma_holds, m_cpu_won_last;
    int   m_beats, m_cg, m_dg, m_cf;
    bit   e_cpu, e_dma, conf, e_we, e_crv, e_drv, inflight, e_stall;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_data;

    always @(negedge clk) begin
        if (!reset_n) begin
            m_cpu_owed = 0; m_dma_holds = 0; m_cpu_won_last = 0; m_beats = 0;
            m_cg = 0; m_dg = 0; m_cf = 0;
            q.delete();
            chk("rst_ctl", {bus.cpu_gnt, bus.dma_gnt, bus.mem_en, bus.mem_we,
                            bus.cpu_rvalid, bus.dma_rvalid, bus.cpu_stall}, 0);
            chk("rst_bus", {bus.mem_addr, bus.mem_wdata}, 0);
            chk("rst_rdata", {bus.cpu_rdata, bus.dma_rdata}, 0);
            chk("rst_stats", {bus.stat_cpu_grants, bus.stat_dma_grants, bus.stat_conflicts}, 0);
        end else begin
            e_cpu = 0; e_dma = 0; conf = 0;
            if (m_cpu_owed) e_cpu = bus.cpu_req;
            else if (m_dma_holds)
                e_dma = bus.dma_req && bus.dma_lock && !(m_beats >= MAX_BURST && bus.cpu_req);
            else if (bus.cpu_req && bus.dma_req) begin
                conf = 1;
                if (m_cpu_won_last) e_dma = 1; else e_cpu = 1;
            end else begin
                e_cpu = bus.cpu_req;
                e_dma = bus.dma_req;
            end
            e_we    = e_cpu ? bus.cpu_we    : (e_dma ? bus.dma_we    : 1'b0);
            e_addr  = e_cpu ? bus.cpu_addr  : (e_dma ? bus.dma_addr  : '0);
            e_wdata = e_cpu ? bus.cpu_wdata : (e_dma ? bus.dma_wdata : '0);
            e_crv = 0; e_drv = 0; e_data = '0; inflight = 0;
            foreach (q[i]) begin
                if (q[i].due == cyc) begin
                    if (q[i].cpu) e_crv = 1; else e_drv = 1;
                    e_data = q[i].data;
                end
                if (q[i].cpu) inflight = 1;
            end
            e_stall = (bus.cpu_req && !e_cpu) || inflight;

            chk("gnt", {bus.cpu_gnt, bus.dma_gnt}, {e_cpu, e_dma});
            chk("mem_ctl", {bus.mem_en, bus.mem_we}, {e_cpu | e_dma, e_we});
            chk("mem_addr", bus.mem_addr, e_addr);
            chk("mem_wdata", bus.mem_wdata, e_wdata);
            chk("rvalid", {bus.cpu_rvalid, bus.dma_rvalid}, {e_crv, e_drv});
            chk("stall", bus.cpu_stall, e_stall);
            if (e_crv) chk("cpu_rdata", bus.cpu_rdata, e_data);
            if (e_drv) chk("dma_rdata", bus.dma_rdata, e_data);
            chk("rdata_pass", {bus.cpu_rdata, bus.dma_rdata}, {bus.mem_rdata, bus.mem_rdata});
            chk("stats", {bus.stat_cpu_grants, bus.stat_dma_grants, bus.stat_conflicts},
                C_STATS ? {CNT_W'(m_cg), CNT_W'(m_dg), CNT_W'(m_cf)} : 0);

            if (e_cpu && m_cg < SAT) m_cg++;
            if (e_dma && m_dg < SAT) m_dg++;
            if (conf && m_cf < SAT) m_cf++;
            if ((e_cpu && !bus.cpu_we) || (e_dma && !bus.dma_we)) begin
                ent.due = cyc + MEM_LAT; ent.cpu = e_cpu; ent.data = mem[e_addr[9:2]];
                q.push_back(ent);
            end
            if (m_cpu_owed) begin
                if (e_cpu) begin m_cpu_owed = 0; m_cpu_won_last = 1; m_beats = 0; end
            end else if (m_dma_holds) begin
                if (!(bus.dma_req && bus.dma_lock)) m_dma_holds = 0;
                else if (m_beats >= MAX_BURST && bus.cpu_req) begin m_dma_holds = 0; m_cpu_owed = 1; end
                else if (m_beats < MAX_BURST) m_beats++;
            end else begin
                if (conf) m_cpu_won_last = e_cpu;
                if (e_dma && bus.dma_lock) begin m_dma_holds = 1; m_beats = 1; end
            end
            nq.delete();
            foreach (q[i]) if (q[i].due > cyc) nq.push_back(q[i]);
            q = nq;
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.dma_req = 0; bus.dma_we = 0; bus.dma_addr = '0; bus.dma_wdata = '0; bus.dma_lock = 0;
    endtask

    task automatic rst_pulse();
        clear_inputs();
        reset_n = 0;
        tick(); tick();
        reset_n = 1;
    endtask

    int  b, n, cpu_at, n_g;
    bit  cpu_done, dg, cg;

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 0;
        clear_inputs();
        bus.cpu_req = 1; bus.cpu_addr = 32'h40;
        @(negedge clk);
        chk("reset_gnt_low", {bus.cpu_gnt, bus.mem_en, bus.cpu_stall}, 0);
        tick(); tick();
        reset_n = 1;

        // CPU-only read at 0x40, two-cycle memory latency
        @(negedge clk);
        chk("s1_c0", {bus.cpu_gnt, bus.mem_en, bus.mem_we, bus.cpu_stall}, 4'b1100);
        chk("s1_addr", bus.mem_addr, 32'h40);
        tick(); bus.cpu_req = 0;
        @(negedge clk);
        chk("s1_c1", {bus.cpu_rvalid, bus.cpu_stall}, 2'b01);
        tick();
        @(negedge clk);
        chk("s1_c2", {bus.cpu_rvalid, bus.cpu_stall}, 2'b11);
        chk("s1_rdata", bus.cpu_rdata, 32'hC0DE_0010);
        tick();
        @(negedge clk);
        chk("s1_c3", {bus.cpu_rvalid, bus.cpu_stall}, 2'b00);

        // Simultaneous requests straight after reset
        rst_pulse();
        bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 32'h10; bus.cpu_wdata = 32'h1111;
        bus.dma_req = 1; bus.dma_we = 1; bus.dma_addr = 32'h20; bus.dma_wdata = 32'h2222;
        @(negedge clk);
        chk("s2_first", {bus.cpu_gnt, bus.dma_gnt}, 2'b10);
        tick();
        @(negedge clk);
        chk("s2_second", {bus.cpu_gnt, bus.dma_gnt}, 2'b01);
        tick(); clear_inputs();
        @(negedge clk);
        chk("s2_conflicts", bus.stat_conflicts, C_STATS ? 2 : 0);
        tick();

        // 12-beat locked write burst, CPU arrives at beat 3
        b = 0; n = 0; cpu_done = 0; cpu_at = -1;
        while (b < 12 && n < 60) begin
            bus.dma_req = 1; bus.dma_lock = 1; bus.dma_we = 1;
            bus.dma_addr = 32'h100 + 4 * b; bus.dma_wdata = 32'hD000_0000 + b;
            if (b >= 2 && !cpu_done) begin
                bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 32'h80; bus.cpu_wdata = 32'hCAFE;
            end
            @(negedge clk);
            dg = bus.dma_gnt; cg = bus.cpu_gnt;
            tick(); n++;
            if (dg) b++;
            if (cg) begin cpu_done = 1; cpu_at = b; bus.cpu_req = 0; end
        end
        clear_inputs();
        chk("s3_cpu_slot", cpu_at, 8);
        chk("s3_cycles", n, 14);
        tick();

        // 20-beat locked read burst with no CPU traffic
        n_g = 0;
        for (int i = 0; i < 20; i++) begin
            bus.dma_req = 1; bus.dma_lock = 1; bus.dma_we = 0; bus.dma_addr = 32'h100 + 4 * i;
            @(negedge clk);
            if (bus.dma_gnt) n_g++;
            tick();
        end
        clear_inputs();
        chk("s4_beats", n_g, 20);
        repeat (MEM_LAT + 1) tick();

        // DMA read dropped by a reset pulse
        bus.dma_req = 1; bus.dma_we = 0; bus.dma_addr = 32'h44;
        @(negedge clk);
        chk("s5_dma_gnt", bus.dma_gnt, 1);
        tick();
        bus.dma_req = 0; reset_n = 0;
        bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 32'h48; bus.cpu_wdata = 32'h5555;
        @(negedge clk);
        chk("s5_in_reset", {bus.dma_gnt, bus.cpu_gnt, bus.mem_en, bus.dma_rvalid, bus.cpu_stall}, 0);
        tick();
        reset_n = 1;
        @(negedge clk);
        chk("s5_release", {bus.cpu_gnt, bus.dma_rvalid}, 2'b10);
        tick(); bus.cpu_req = 0;
        @(negedge clk);
        chk("s5_no_return", bus.dma_rvalid, 0);
        tick();

        // Counter saturation after 20 CPU accepts
        rst_pulse();
        bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 32'h0C;
        for (int i = 0; i < 20; i++) begin
            bus.cpu_wdata = i;
            tick();
        end
        clear_inputs();
        @(negedge clk);
        chk("s6_cpu_sat", bus.stat_cpu_grants, C_STATS ? 15 : 0);
        chk("s6_dma_zero", bus.stat_dma_grants, 0);
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified instruction/data memory port between the multicycle CPU datapath and a DMA/program-loader master.
- Sits between the CPU's memory interface (address mux, write data, write strobe) and the memory macro.
- Issues at most one access per cycle, routes read data back to its issuer, and stalls the CPU while the DMA owns the port.
- Bounds DMA bursts so CPU fetch cannot starve.

Parameters:
- AW, 32, address width
- DW, 32, data width
- MEM_LAT, 1, memory read latency in cycles (legal 1..4)
- MAX_BURST, 8, maximum consecutive locked DMA beats while CPU is waiting (legal 1..255)
- CNT_W, 16, statistics counter width

Ports:
- clk  in  1  clock
- reset_n  in  1  reset; one clock; reset is asynchronous and active-low
- cpu_req  in  1  CPU access request
- cpu_we  in  1  CPU write
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU write data
- cpu_gnt  out  1  CPU access accepted this cycle
- cpu_rvalid  out  1  CPU read data valid
- cpu_rdata  out  DW  CPU read data
- cpu_stall  out  1  hold multicycle FSM in current state
- dma_req  in  1  DMA access request
- dma_we  in  1  DMA write
- dma_addr  in  AW  DMA address
- dma_wdata  in  DW  DMA write data
- dma_lock  in  1  DMA requests burst ownership
- dma_gnt  out  1  DMA access accepted this cycle
- dma_rvalid  out  1  DMA read data valid
- dma_rdata  out  DW  DMA read data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, MEM_LAT cycles after mem_en
- stat_cpu_grants, stat_dma_grants, stat_conflicts  out  CNT_W each  statistics

Behaviour:
- Handshake:
  - Accept = req & gnt in the same cycle.
  - gnt is combinational from state and the req inputs.
  - A requester holds req, we, addr and wdata stable until accepted.
  - At most one of cpu_gnt or dma_gnt is high per cycle.
- Memory drive:
  - mem_en = cpu_gnt | dma_gnt.
  - mem_we, mem_addr and mem_wdata are muxed combinationally from the granted master.
  - When idle, mem_en and mem_we are 0 and mem_addr/mem_wdata are 0.
- Read return:
  - A MEM_LAT-deep shift pipeline of {valid, owner} tags is loaded on every accepted read.
  - cpu_rvalid or dma_rvalid is asserted exactly MEM_LAT cycles after accept, one cycle wide.
  - cpu_rdata = dma_rdata = mem_rdata, unqualified.
  - Writes produce no rvalid.
- FSM states: IDLE, DMA_BURST, CPU_FORCE.
  - IDLE, only one master requests: grant it.
  - IDLE, both request: grant the master that did not win the previous conflict (last_winner flag, toggled on each conflict) and increment stat_conflicts.
  - IDLE: a DMA accept with dma_lock=1 goes to DMA_BURST with beat count = 1.
  - DMA_BURST: only DMA may be granted; each DMA accept increments the beat count.
  - DMA_BURST to IDLE: when dma_lock=0 or dma_req=0, with no grant that cycle.
  - DMA_BURST to CPU_FORCE: when beat count >= MAX_BURST and cpu_req=1; the beat count is held.
  - DMA_BURST, beat count reaches MAX_BURST with cpu_req=0: the burst continues and the count saturates.
  - CPU_FORCE: grant CPU only once cpu_req is high, then go to IDLE with last_winner=CPU and beat count cleared.
  - A locked beat accepted in the same cycle that dma_lock falls counts as the last beat; the next state is IDLE.
- cpu_stall = (cpu_req & ~cpu_gnt) | (a CPU read tag in flight).
- Counters:
  - stat_cpu_grants increments per CPU accept.
  - stat_dma_grants increments per DMA accept.
  - stat_conflicts increments per IDLE conflict cycle.
  - All saturate at all-ones.
- Reset (async assert, sync release):
  - state IDLE, last_winner=DMA (CPU wins the first conflict), beat count 0, tag pipeline cleared.
  - All gnt/rvalid/mem_en/mem_we low; data outputs 0.
  - Reads in flight at reset are dropped and never return rvalid.

Optional Feature:
- Macro ARB_STATS_EN.
- Defined: the three stat_* counters are implemented as above.
- Undefined: no counter registers are built; stat_* ports are tied to 0; arbitration is unchanged.

Test Plan:
- CPU-only read at 0x40 with MEM_LAT=2 -> cpu_gnt in cycle 0, mem_en=1, mem_addr=0x40; cpu_rvalid in cycle 2 with cpu_rdata=mem_rdata; cpu_stall high in cycles 1-2.
- cpu_req and dma_req both high from IDLE after reset for 2 cycles -> CPU granted first, DMA second; stat_conflicts=2.
- DMA locked write burst of 12 beats, MAX_BURST=8, cpu_req rising at beat 3 -> DMA beats 1-8 granted, then one CPU grant, then DMA beats 9-12; cpu_stall high until the CPU grant.
- DMA locked burst with cpu_req=0 throughout -> all 20 beats granted back-to-back; beat count saturates; no CPU_FORCE.
- DMA read accepted, then reset_n pulsed low the next cycle -> no dma_rvalid; all outputs 0 during reset; normal grant on the first cycle after release.
- Stats built with ARB_STATS_EN and CNT_W=4, 20 CPU accepts -> stat_cpu_grants=15 (saturated); without ARB_STATS_EN -> all stat_* read 0.
